// File: rtl/asm_controller.sv
// Counter-ASM control unit: drives datapath t0/t1 and consumes its status flag.
// Define ASM_CTRL_WATCHDOG_EN to build the COUNT watchdog and ERROR state.
module asm_controller #(
    parameter int unsigned MAX_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       status,
    output logic       t0,
    output logic       t1,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    if (MAX_CYCLES < 1 || MAX_CYCLES > 255) begin : g_bad_max
        $error("asm_controller: MAX_CYCLES must be in 1..255");
    end

    logic [2:0] state_q;
    logic [2:0] state_d;

`ifdef ASM_CTRL_WATCHDOG_EN
    localparam logic [7:0] WD_LIMIT = 8'(MAX_CYCLES - 1);

    logic [7:0] wd_q;
    logic [7:0] wd_d;
    logic       wd_trip;

    assign wd_trip = (wd_q == WD_LIMIT);

    always_comb begin
        wd_d = wd_q;
        if (state_q == S_INIT) begin
            wd_d = 8'd0;
        end else if (state_q == S_COUNT && !status) begin
            wd_d = wd_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                state_d = start ? S_INIT : S_IDLE;
            end
            S_INIT: begin
                state_d = S_COUNT;
            end
            S_COUNT: begin
                // status wins over a watchdog trip in the same cycle
                if (status) begin
                    state_d = S_DONE;
`ifdef ASM_CTRL_WATCHDOG_EN
                end else if (wd_trip) begin
                    state_d = S_ERROR;
`endif
                end else begin
                    state_d = S_COUNT;
                end
            end
            S_DONE: begin
                state_d = start ? S_DONE : S_IDLE;
            end
`ifdef ASM_CTRL_WATCHDOG_EN
            S_ERROR: begin
                state_d = start ? S_ERROR : S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        t0   = 1'b0;
        t1   = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (state_q)
            S_INIT: begin
                t0   = 1'b1;
                busy = 1'b1;
            end
            S_COUNT: begin
                t1   = 1'b1;
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
`ifdef ASM_CTRL_WATCHDOG_EN
            S_ERROR: begin
                err = 1'b1;
            end
`endif
            default: begin
                t0 = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_asm_controller.sv
// Directed self-checking bench for asm_controller with a small datapath model.
// Watchdog scenarios follow ASM_CTRL_WATCHDOG_EN.
module tb_asm_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       status;
    logic       t0;
    logic       t1;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state;

    logic       use_dp;
    logic       status_drv;
    logic [3:0] dp_cnt_q;
    logic       dp_status_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Datapath: t0 clears, t1 increments, status registers "next count == 4"
    always_ff @(posedge clk) begin
        if (t0) begin
            dp_cnt_q    <= 4'd0;
            dp_status_q <= 1'b0;
        end else if (t1) begin
            dp_cnt_q    <= dp_cnt_q + 4'd1;
            dp_status_q <= ((dp_cnt_q + 4'd1) == 4'd4);
        end
    end

    assign status = use_dp ? dp_status_q : status_drv;

    asm_controller #(.MAX_CYCLES(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .status (status),
        .t0     (t0),
        .t1     (t1),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .state  (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        checks++;
        if ({state, t0, t1, busy, done, err} !== 8'b000_00000) begin
            errors++;
            $display("FAIL reset_outputs: got state=%0d t0=%b t1=%b busy=%b done=%b err=%b, want all 0",
                     state, t0, t1, busy, done, err);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (t0 !== 1'b0 || state !== 3'd0) begin
                errors++;
                $display("FAIL idle_no_t0: got t0=%b state=%0d, want t0=0 state=0", t0, state);
            end
        end
    endtask

    task automatic test_run();
        int n;
        use_dp = 1'b1;
        start  = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1 || t0 !== 1'b1 || t1 !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_init: got state=%0d t0=%b t1=%b busy=%b, want 1 1 0 1",
                     state, t0, t1, busy);
        end
        tick();
        n = 0;
        while (t1 === 1'b1 && n < 40) begin
            if (t0 !== 1'b0) begin
                errors++;
                $display("FAIL run_t0_in_count: got t0=%b, want 0", t0);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL run_t1_cycles: got %0d, want 5", n);
        end
        checks++;
        if (state !== 3'd3 || done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL run_done: got state=%0d done=%b busy=%b err=%b, want 3 1 0 0",
                     state, done, busy, err);
        end
    endtask

    task automatic test_hold_start();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (state !== 3'd3 || done !== 1'b1 || t0 !== 1'b0) begin
                errors++;
                $display("FAIL hold_done: got state=%0d done=%b t0=%b, want 3 1 0",
                         state, done, t0);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL drop_to_idle: got state=%0d done=%b, want 0 0", state, done);
        end
        use_dp = 1'b0;
    endtask

    task automatic test_watchdog();
        int n;
        status_drv = 1'b0;
        start      = 1'b1;
        tick();
        tick();
        n = 0;
        while (t1 === 1'b1 && n < 40) begin
            n++;
            tick();
        end
`ifdef ASM_CTRL_WATCHDOG_EN
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL wd_t1_cycles: got %0d, want 16", n);
        end
        checks++;
        if (state !== 3'd4 || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_error: got state=%0d err=%b done=%b busy=%b, want 4 1 0 0",
                     state, err, done, busy);
        end
        tick();
        tick();
        checks++;
        if (state !== 3'd4 || err !== 1'b1) begin
            errors++;
            $display("FAIL wd_hold: got state=%0d err=%b, want 4 1", state, err);
        end
`else
        checks++;
        if (n != 40 || state !== 3'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL nowd_stay_count: got n=%0d state=%0d err=%b, want 40 2 0",
                     n, state, err);
        end
        status_drv = 1'b1;
        tick();
        status_drv = 1'b0;
        checks++;
        if (state !== 3'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL nowd_done: got state=%0d done=%b, want 3 1", state, done);
        end
`endif
        start = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL wd_drop: got state=%0d err=%b, want 0 0", state, err);
        end
    endtask

    task automatic test_status_at_limit();
        status_drv = 1'b0;
        start      = 1'b1;
        tick();
        tick();
        for (int i = 2; i <= 16; i++) begin
            tick();
        end
        checks++;
        if (state !== 3'd2 || t1 !== 1'b1) begin
            errors++;
            $display("FAIL limit_in_count: got state=%0d t1=%b, want 2 1", state, t1);
        end
        status_drv = 1'b1;
        tick();
        status_drv = 1'b0;
        checks++;
        if (state !== 3'd3 || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL limit_status_wins: got state=%0d done=%b err=%b, want 3 1 0",
                     state, done, err);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_min_run();
        status_drv = 1'b1;
        start      = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 3'd2 || t1 !== 1'b1) begin
            errors++;
            $display("FAIL min_count: got state=%0d t1=%b, want 2 1", state, t1);
        end
        tick();
        checks++;
        if (state !== 3'd3 || done !== 1'b1 || t1 !== 1'b0) begin
            errors++;
            $display("FAIL min_done: got state=%0d done=%b t1=%b, want 3 1 0",
                     state, done, t1);
        end
        status_drv = 1'b0;
        start      = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int n;
        status_drv = 1'b0;
        start      = 1'b1;
        tick();
        tick();
        tick();
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (state !== 3'd0 || t1 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got state=%0d t1=%b busy=%b, want 0 0 0",
                     state, t1, busy);
        end
        start = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1 || t0 !== 1'b1) begin
            errors++;
            $display("FAIL midrun_restart: got state=%0d t0=%b, want 1 1", state, t0);
        end
        tick();
        n = 0;
        while (t1 === 1'b1 && n < 40) begin
            n++;
            tick();
        end
`ifdef ASM_CTRL_WATCHDOG_EN
        checks++;
        if (n != 16 || state !== 3'd4) begin
            errors++;
            $display("FAIL midrun_wd_fresh: got n=%0d state=%0d, want 16 4", n, state);
        end
`else
        checks++;
        if (n != 40 || state !== 3'd2) begin
            errors++;
            $display("FAIL midrun_stay: got n=%0d state=%0d, want 40 2", n, state);
        end
        status_drv = 1'b1;
        tick();
        status_drv = 1'b0;
`endif
        start = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL midrun_idle: got state=%0d, want 0", state);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        use_dp     = 1'b0;
        status_drv = 1'b0;
        test_reset();
        test_run();
        test_hold_start();
        test_watchdog();
        test_status_at_limit();
        test_min_run();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
